// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window sequencer.
// Optional statistics counters are enabled by SOBEL_WINDOW_CTRL_STATS_EN.
package sobel_pkg;

    // state | meaning
    // IDLE   | waiting for the first pixel of a frame
    // PRIME  | filling the delay lines, no complete window yet
    // STREAM | every beat completes a window
    // FLUSH  | zero beats push the last rows out of the chain
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } win_state_e;

    localparam int FRAME_CNT_W = 16;
    localparam int STALL_CNT_W = 32;

    // One line of zeros plus one beat drains the final window centre.
    function automatic int flush_beats(input int cols);
        return cols + 1;
    endfunction

endpackage

// File: rtl/sobel_pos_counter.sv
// Row/column wrap counter: column wraps at COLS_P-1 and carries into the row,
// row wraps at ROWS_P-1. Clear has priority over advance.
module sobel_pos_counter
#(
    parameter int ROWS_P = 480,
    parameter int COLS_P = 640,
    parameter int RW_P   = $clog2(ROWS_P),
    parameter int CW_P   = $clog2(COLS_P)
)
(
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            clr_i,
    input  logic            adv_i,
    output logic [RW_P-1:0] row_o,
    output logic [CW_P-1:0] col_o
);

    localparam logic [RW_P-1:0] ROW_MAX = RW_P'(ROWS_P - 1);
    localparam logic [CW_P-1:0] COL_MAX = CW_P'(COLS_P - 1);

    // Raster-order position register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            row_o <= '0;
            col_o <= '0;
        end else if (clr_i) begin
            row_o <= '0;
            col_o <= '0;
        end else if (adv_i) begin
            if (col_o == COL_MAX) begin
                col_o <= '0;
                row_o <= (row_o == ROW_MAX) ? '0 : row_o + RW_P'(1);
            end else begin
                col_o <= col_o + CW_P'(1);
            end
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Line-buffer chain sequencer for the Sobel front end: forwards pixels,
// tags each completed 3x3 window with its centre and border flag, and
// flushes the chain with zero beats at frame end.
// Define SOBEL_WINDOW_CTRL_STATS_EN to add frame and stall counters.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH_P = 8,
    parameter int COLS_P  = 640,
    parameter int ROWS_P  = 480
)
(
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [WIDTH_P-1:0]        data_i,
    output logic                      lb_valid_o,
    input  logic                      lb_ready_i,
    output logic [WIDTH_P-1:0]        lb_data_o,
    output logic                      win_valid_o,
    output logic [$clog2(ROWS_P)-1:0] win_row_o,
    output logic [$clog2(COLS_P)-1:0] win_col_o,
    output logic                      border_o,
    output logic                      busy_o,
    output logic                      frame_done_o
`ifdef SOBEL_WINDOW_CTRL_STATS_EN
    ,
    output logic [FRAME_CNT_W-1:0]    frame_cnt_o,
    output logic [STALL_CNT_W-1:0]    stall_cnt_o
`endif
);

    localparam int RW          = $clog2(ROWS_P);
    localparam int CW          = $clog2(COLS_P);
    localparam int FLUSH_BEATS = flush_beats(COLS_P);

    // Beat indices of interest within a frame.
    localparam int P_PRIME_END = COLS_P + 1;
    localparam int P_LAST_PIX  = ROWS_P * COLS_P - 1;
    localparam int P_END       = P_LAST_PIX + FLUSH_BEATS;

    // The beat counter p is kept as (row, col) of a raster that is
    // long enough to reach P_END, so p = brow*COLS_P + bcol.
    localparam int BROWS = P_END / COLS_P + 1;
    localparam int BRW   = $clog2(BROWS);

    localparam logic [BRW-1:0] PRIME_ROW = BRW'(P_PRIME_END / COLS_P);
    localparam logic [CW-1:0]  PRIME_COL = CW'(P_PRIME_END % COLS_P);
    localparam logic [BRW-1:0] LAST_ROW  = BRW'(P_LAST_PIX / COLS_P);
    localparam logic [CW-1:0]  LAST_COL  = CW'(P_LAST_PIX % COLS_P);
    localparam logic [BRW-1:0] END_ROW   = BRW'(P_END / COLS_P);
    localparam logic [CW-1:0]  END_COL   = CW'(P_END % COLS_P);
    localparam logic [RW-1:0]  CROW_MAX  = RW'(ROWS_P - 1);
    localparam logic [CW-1:0]  CCOL_MAX  = CW'(COLS_P - 1);

    win_state_e     state;
    win_state_e     state_next;
    logic           in_flush;
    logic           beat;
    logic [BRW-1:0] brow;
    logic [CW-1:0]  bcol;
    logic           at_prime_end;
    logic           at_last_pix;
    logic           at_end;
    logic           past_prime;
    logic           win_en;
    logic           frame_end;
    logic [RW-1:0]  crow;
    logic [CW-1:0]  ccol;
    logic           border;

    assign in_flush = (state == FLUSH);
    assign busy_o   = (state != IDLE);
    assign beat     = lb_valid_o & lb_ready_i;

    // Pass-through handshake; FLUSH substitutes zero beats and blocks upstream.
    always_comb begin
        ready_o    = lb_ready_i;
        lb_valid_o = valid_i;
        lb_data_o  = data_i;
        if (in_flush) begin
            ready_o    = 1'b0;
            lb_valid_o = 1'b1;
            lb_data_o  = '0;
        end
    end

    assign at_prime_end = (brow == PRIME_ROW) && (bcol == PRIME_COL);
    assign at_last_pix  = (brow == LAST_ROW)  && (bcol == LAST_COL);
    assign at_end       = (brow == END_ROW)   && (bcol == END_COL);
    assign past_prime   = (brow > PRIME_ROW) || ((brow == PRIME_ROW) && (bcol >= PRIME_COL));
    assign win_en       = beat && past_prime;
    assign frame_end    = beat && in_flush && at_end;

    sobel_pos_counter #(
        .ROWS_P (BROWS),
        .COLS_P (COLS_P),
        .RW_P   (BRW),
        .CW_P   (CW)
    ) u_beat_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (frame_end),
        .adv_i  (beat),
        .row_o  (brow),
        .col_o  (bcol)
    );

    sobel_pos_counter #(
        .ROWS_P (ROWS_P),
        .COLS_P (COLS_P),
        .RW_P   (RW),
        .CW_P   (CW)
    ) u_centre_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (frame_end),
        .adv_i  (win_en),
        .row_o  (crow),
        .col_o  (ccol)
    );

    assign border = (crow == '0) || (crow == CROW_MAX) || (ccol == '0) || (ccol == CCOL_MAX);

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: every transition is qualified by a beat at a fixed index.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (beat) state_next = PRIME;
            PRIME:   if (beat && at_prime_end) state_next = STREAM;
            STREAM:  if (beat && at_last_pix) state_next = FLUSH;
            FLUSH:   if (frame_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Window tag registers; aligned with the delay-line output register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            win_valid_o  <= 1'b0;
            win_row_o    <= '0;
            win_col_o    <= '0;
            border_o     <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            win_valid_o  <= win_en;
            frame_done_o <= frame_end;
            if (win_en) begin
                win_row_o <= crow;
                win_col_o <= ccol;
                border_o  <= border;
            end
        end
    end

`ifdef SOBEL_WINDOW_CTRL_STATS_EN
    logic stall;
    assign stall = busy_o & lb_valid_o & ~lb_ready_i;

    // Frame counter wraps; stall counter saturates and restarts each frame.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            frame_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (frame_done_o) begin
                frame_cnt_o <= frame_cnt_o + FRAME_CNT_W'(1);
            end
            if (beat && (state == IDLE)) begin
                stall_cnt_o <= '0;
            end else if (stall && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl at COLS=4, ROWS=3, WIDTH=8.
module tb_sobel_window_ctrl;

    localparam int W = 8;
    localparam int C = 4;
    localparam int R = 3;

    logic           clk_i;
    logic           rstn_i;
    logic           valid_i;
    logic           ready_o;
    logic [W-1:0]   data_i;
    logic           lb_valid_o;
    logic           lb_ready_i;
    logic [W-1:0]   lb_data_o;
    logic           win_valid_o;
    logic [1:0]     win_row_o;
    logic [1:0]     win_col_o;
    logic           border_o;
    logic           busy_o;
    logic           frame_done_o;
`ifdef SOBEL_WINDOW_CTRL_STATS_EN
    logic [15:0]    frame_cnt_o;
    logic [31:0]    stall_cnt_o;
`endif

    sobel_window_ctrl #(.WIDTH_P(W), .COLS_P(C), .ROWS_P(R)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .lb_valid_o   (lb_valid_o),
        .lb_ready_i   (lb_ready_i),
        .lb_data_o    (lb_data_o),
        .win_valid_o  (win_valid_o),
        .win_row_o    (win_row_o),
        .win_col_o    (win_col_o),
        .border_o     (border_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
`ifdef SOBEL_WINDOW_CTRL_STATS_EN
        ,
        .frame_cnt_o  (frame_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: plain frame arithmetic.
    int          beats_done;     // beats accepted so far in the current frame
    int          win_count;      // windows seen in total
    int          exp_row;
    int          exp_col;
    bit          exp_border;
    bit          frame_just_done;
    int          exp_stall;
    int          exp_fcnt;
    bit          done_pending;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        beats_done      = 0;
        exp_row         = 0;
        exp_col         = 0;
        exp_border      = 1'b0;
        frame_just_done = 1'b0;
        exp_stall       = 0;
        exp_fcnt        = 0;
        done_pending    = 1'b0;
    endtask

    // One clock: drive at negedge, check combinational path, then registered outputs.
    task automatic step(input bit v, input bit r, input logic [W-1:0] d);
        bit flush, beat, ewin, edone, busy_before;
        int p, k;
        valid_i    = v;
        lb_ready_i = r;
        data_i     = d;
        #1;
        flush       = (beats_done >= R * C);
        busy_before = (beats_done > 0);
        if (flush) begin
            chk("flush_ready", ready_o, 0);
            chk("flush_valid", lb_valid_o, 1);
            chk("flush_data", lb_data_o, 0);
        end else begin
            chk("pass_ready", ready_o, r);
            chk("pass_valid", lb_valid_o, v);
            chk("pass_data", lb_data_o, d);
        end
        beat = (flush ? 1'b1 : v) & r;
        p    = beats_done;
        @(posedge clk_i);
        #1;
        if (done_pending) exp_fcnt = (exp_fcnt + 1) % 65536;
        if (beat && p == 0) exp_stall = 0;
        else if (busy_before && (flush || v) && !r && exp_stall != 32'hFFFF_FFFF) exp_stall++;
        ewin  = 1'b0;
        edone = 1'b0;
        if (beat) begin
            ewin  = (p >= C + 1);
            edone = (p == R * C + C);
            if (ewin) begin
                k          = p - (C + 1);
                exp_row    = k / C;
                exp_col    = k % C;
                exp_border = (exp_row == 0) || (exp_row == R - 1) ||
                             (exp_col == 0) || (exp_col == C - 1);
                win_count++;
            end
            beats_done = edone ? 0 : p + 1;
        end
        done_pending    = edone;
        frame_just_done = edone;
        chk("win_valid", win_valid_o, ewin);
        chk("win_row", win_row_o, exp_row);
        chk("win_col", win_col_o, exp_col);
        chk("border", border_o, exp_border);
        chk("frame_done", frame_done_o, edone);
        chk("busy", busy_o, beats_done > 0);
`ifdef SOBEL_WINDOW_CTRL_STATS_EN
        chk("frame_cnt", frame_cnt_o, exp_fcnt);
        chk("stall_cnt", stall_cnt_o, exp_stall);
`endif
        @(negedge clk_i);
    endtask

    // mode 0: always valid/ready; 1: random; 2: valid high, ready low on cycles 8..10.
    task automatic run_frame(input int mode);
        int  start;
        bit  done;
        bit  v, r;
        start = win_count;
        done  = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            case (mode)
                0: begin v = 1'b1; r = 1'b1; end
                1: begin v = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
                default: begin v = 1'b1; r = !(c >= 8 && c <= 10); end
            endcase
            step(v, r, W'($urandom));
            if (mode == 0 && c == 0) chk("first_beat_immediate", busy_o, 1);
            done = frame_just_done;
        end
        chk("frame_complete", done, 1);
        chk("frame_windows", win_count - start, R * C);
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_win_valid", win_valid_o, 0);
        chk("rst_frame_done", frame_done_o, 0);
        chk("rst_row", win_row_o, 0);
        chk("rst_col", win_col_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        model_reset();
    endtask

    initial begin
        rstn_i     = 1'b0;
        valid_i    = 1'b0;
        lb_ready_i = 1'b0;
        data_i     = '0;
        win_count  = 0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        do_reset();
        chk("rst_border", border_o, 0);

        // Frame with constant ready.
        run_frame(0);
        // Random valid / ready stalls.
        run_frame(1);
        run_frame(1);
        // Back-to-back frames with valid held high.
        run_frame(0);
        run_frame(0);
        // Idle cycles with ready low: nothing moves.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);

        // Reset mid-frame after the 7th beat, then a clean frame.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, W'($urandom));
        chk("mid_frame_beats", beats_done, 7);
        do_reset();
        run_frame(0);

`ifdef SOBEL_WINDOW_CTRL_STATS_EN
        do_reset();
        run_frame(2);
        chk("stats_stall_f1", stall_cnt_o, 3);
        run_frame(0);
        step(1'b0, 1'b1, 8'h00);
        chk("stats_frame_cnt", frame_cnt_o, 2);
        chk("stats_stall_f2", stall_cnt_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
